write_buffer_responder: RTL

Target-side end of the output-buffer write handshake: receives write_req / write_in_buffer from the producer controller, answers with ready, and stores the data word in an internal FIFO.
- Grants at most one outstanding write at a time and reserves a slot before asserting ready, so a granted write can never overflow.
- Drains stored words to the downstream consumer over a valid/ready interface.

---
 rtl/write_buffer_pkg.sv | 16 +
 rtl/buffer_fifo.sv | 68 ++++++
 rtl/write_buffer_responder.sv | 99 +++++++++
 3 files changed

// File: rtl/write_buffer_pkg.sv
// Shared definitions for the output-buffer write handshake.
// Holds the responder FSM state encoding and the default data width / FIFO
// depth, so the producer-side controller bench can use the same encoding.
package write_buffer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,  // waiting for write_req
      PEND   = 2'd1,  // request seen while full, waiting for a free slot
      GRANT  = 2'd2,  // slot reserved, ready asserted for this cycle
      W_DATA = 2'd3   // waiting for the producer data strobe
   } wb_state_e;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_DEPTH  = 4;

endpackage

// File: rtl/buffer_fifo.sv
// Storage FIFO for the write buffer responder, with show-ahead output.
// Ports:
//   clk, rst        - clock (rising edge), asynchronous active-low reset
//   push, push_data - write push_data at the tail this cycle
//   pop             - consumer handshake; ignored while empty
//   out_data        - word at the head of the FIFO
//   level           - number of stored entries (0..DEPTH)
// The caller never pushes into a full FIFO (a slot is reserved before the
// grant), so push is not gated against full here.
module buffer_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  level_q, level_d;
   logic              pop_eff;
   logic [DATA_W-1:0] mem [DEPTH];

   // A pop against an empty FIFO is a no-op.
   assign pop_eff = pop && (level_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push)
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_eff)
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      // Simultaneous push and pop cancel out on the level.
      level_d = level_q + CNT_W'(push) - CNT_W'(pop_eff);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage has no reset; contents behind the pointers are don't-care.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_q] <= push_data;
   end

   assign out_data = mem[rd_ptr_q];
   assign level    = level_q;

endmodule

// File: rtl/write_buffer_responder.sv
// Target side of the output-buffer write handshake.
// Grants one outstanding write at a time: a slot is known free before ready
// is raised, so the producer's data strobe can always be stored.
// Ports:
//   clk, rst                       - clock, asynchronous active-low reset
//   write_req                      - producer asks for a slot
//   write_in_buffer, in_data       - producer data strobe and word
//   ready                          - one-cycle grant pulse (state == GRANT)
//   out_valid, out_data, out_ready - show-ahead drain to the consumer
//   full, level                    - FIFO occupancy
//   proto_err                      - sticky: strobe seen outside W_DATA
module write_buffer_responder
   import write_buffer_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              write_req,
   input  logic              write_in_buffer,
   input  logic [DATA_W-1:0] in_data,
   output logic              ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              full,
   output logic [CNT_W-1:0]  level,
   output logic              proto_err
);

   wb_state_e state_q, state_d;
   logic      proto_err_q, proto_err_d;
   logic      push;
   logic      pop;

   assign out_valid = (level != '0);
   assign full      = (level == CNT_W'(DEPTH));
   assign pop       = out_valid && out_ready;

   always_comb begin
      state_d     = state_q;
      push        = 1'b0;
      proto_err_d = proto_err_q;
      case (state_q)
         IDLE: begin
            if (write_req)
               state_d = full ? PEND : GRANT;
         end
         PEND: begin
            // A pop this cycle frees a slot at the edge, so grant right away.
            if (!full || pop)
               state_d = GRANT;
         end
         GRANT: begin
            state_d = W_DATA;
         end
         W_DATA: begin
            if (write_in_buffer) begin
               push    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Strobes outside W_DATA are dropped and flagged until reset.
      if (write_in_buffer && (state_q != W_DATA))
         proto_err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign ready     = (state_q == GRANT);
   assign proto_err = proto_err_q;

   buffer_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (in_data),
      .pop       (pop),
      .out_data  (out_data),
      .level     (level)
   );

endmodule
